// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the sequenced ALU / multiplier block:
//   - state_t      : FSM state encoding of alu_mul_seq
//   - FN_*         : 4-bit ALU function codes understood by ALU_top_module
//   - OP_MUL_BIT   : bit of req_op that selects the multiply operation
//   - XLEN         : datapath width
//   - MUL_ITERS    : iteration count of a full-length multiply
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EXEC      = 3'd1,
    MUL_ADD   = 3'd2,
    MUL_SHIFT = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SLL  = 4'b0001;
  localparam logic [3:0] FN_SLT  = 4'b0010;
  localparam logic [3:0] FN_SLTU = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_SRL  = 4'b0101;
  localparam logic [3:0] FN_OR   = 4'b0110;
  localparam logic [3:0] FN_AND  = 4'b0111;
  localparam logic [3:0] FN_SUB  = 4'b1000;
  localparam logic [3:0] FN_PASS = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1101;

  localparam int OP_MUL_BIT = 4;

  localparam logic [5:0] MUL_ITERS = 6'd32;

endpackage

// File: rtl/ALU_top_module.sv
// ---------------------------------------------------------------------------
// ALU_top_module
//   Purely combinational 32-bit ALU. Undefined function codes yield zero.
//   Ports:
//     op_1   in  [XLEN-1:0] first operand
//     op_2   in  [XLEN-1:0] second operand; [4:0] is the shift amount
//     fn     in  [3:0]      function code (FN_* in alu_seq_pkg)
//     result out [XLEN-1:0] result, wrapped modulo 2^XLEN
// ---------------------------------------------------------------------------
module ALU_top_module
  import alu_seq_pkg::*;
(
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  input  logic [3:0]      fn,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = op_2[4:0];

  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    result = '0;
    case (fn)
      FN_ADD:  result = op_1 + op_2;
      FN_SLL:  result = op_1 << shamt;
      FN_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      FN_SLTU: result = {{(XLEN-1){1'b0}}, (op_1 < op_2)};
      FN_XOR:  result = op_1 ^ op_2;
      FN_SRL:  result = op_1 >> shamt;
      FN_OR:   result = op_1 | op_2;
      FN_AND:  result = op_1 & op_2;
      FN_SUB:  result = op_1 - op_2;
      FN_PASS: result = op_1;
      FN_SRA:  result = $unsigned($signed(op_1) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Request/response wrapper around a single shared ALU. ALU ops take one
//   execute cycle; MUL (req_op[4]=1) runs a shift-and-add loop through the
//   same ALU, two cycles per multiplier bit, optionally ending early once the
//   remaining multiplier is zero.
//   Parameters:
//     MUL_EARLY_EXIT 1 = stop when remaining multiplier is 0, 0 = always 32
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     req_valid/ready   request handshake (ready only in IDLE)
//     req_op [4:0]      bit4 = MUL, else [3:0] = ALU function code
//     req_a, req_b      operands / multiplicand, multiplier
//     rsp_valid/ready   response handshake (valid only in RESP)
//     rsp_result        registered result, stable while in RESP
//     busy              high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter bit MUL_EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy
);

  state_t state, state_next;

  // For ALU ops mcand/mplier simply hold operand a/b; for MUL they are the
  // working multiplicand and multiplier.
  logic [3:0]      fn_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [5:0]      count;

  logic [XLEN-1:0] alu_op_1, alu_op_2, alu_result;
  logic [3:0]      alu_fn;

  logic            accept;
  logic [XLEN-1:0] mplier_shr;
  logic [5:0]      count_inc;
  logic            mul_done;

  assign accept     = req_valid && req_ready;
  assign mplier_shr = mplier >> 1;
  assign count_inc  = count + 6'd1;
  assign mul_done   = (count_inc == MUL_ITERS) ||
                      (MUL_EARLY_EXIT && (mplier_shr == '0));

  ALU_top_module u_alu (
    .op_1   (alu_op_1),
    .op_2   (alu_op_2),
    .fn     (alu_fn),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, ALU operand/function muxes, handshake outputs
  always_comb begin
    state_next = state;
    alu_op_1   = '0;
    alu_op_2   = '0;
    alu_fn     = FN_ADD;

    unique case (state)
      IDLE: begin
        if (req_valid) state_next = req_op[OP_MUL_BIT] ? MUL_ADD : EXEC;
      end
      EXEC: begin
        alu_op_1   = mcand;
        alu_op_2   = mplier;
        alu_fn     = fn_q;
        state_next = RESP;
      end
      MUL_ADD: begin
        alu_op_1   = acc;
        alu_op_2   = mcand;
        alu_fn     = FN_ADD;
        state_next = MUL_SHIFT;
      end
      MUL_SHIFT: begin
        alu_op_1   = mcand;
        alu_op_2   = {{(XLEN-1){1'b0}}, 1'b1};
        alu_fn     = FN_SLL;
        state_next = mul_done ? RESP : MUL_ADD;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_q       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      rsp_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            fn_q   <= req_op[3:0];
            mcand  <= req_a;
            mplier <= req_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        // Undefined codes produce 0 from the ALU, so the result register is
        // always overwritten here and never keeps a previous answer.
        EXEC: rsp_result <= alu_result;
        MUL_ADD: begin
          if (mplier[0]) acc <= alu_result;
        end
        MUL_SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier_shr;
          count  <= count_inc;
          // acc is final here: the last add happened in the preceding MUL_ADD.
          if (mul_done) rsp_result <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//   Self-checking bench for alu_mul_seq. Two instances: dut 0 with early
//   exit enabled, dut 1 with MUL_EARLY_EXIT=0. A table of directed vectors
//   gives expected result and latency (edges from acceptance to rsp_valid),
//   followed by hand-written backpressure and reset sequences.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

  localparam logic [4:0] OP_MUL = 5'b10000;

  typedef struct {
    string       name;
    int          sel;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  rsp_ready = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  busy;
  logic [31:0] res0, res1;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mul_seq #(.MUL_EARLY_EXIT(1'b1)) dut_ee (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid[0]),
    .rsp_ready  (rsp_ready[0]),
    .rsp_result (res0),
    .busy       (busy[0])
  );

  alu_mul_seq #(.MUL_EARLY_EXIT(1'b0)) dut_ne (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid[1]),
    .rsp_ready  (rsp_ready[1]),
    .rsp_result (res1),
    .busy       (busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input int sel, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
    vec_t v;
    v.name = name; v.sel = sel; v.op = op; v.a = a; v.b = b;
    v.exp_res = exp_res; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // Presents one request, waits (bounded) for rsp_valid and returns the
  // result and the number of edges from acceptance to rsp_valid.
  task automatic issue(input int sel, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b;
    req_valid[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    lat = 0;
    while (!rsp_valid[sel] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (sel == 0) ? res0 : res1;
  endtask

  // Takes the response with a one-cycle rsp_ready pulse.
  task automatic consume(input int sel);
    @(negedge clk);
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          stable;
    bit          seen;

    // ALU vectors (dut 0), latency 1
    add_vec("add_wrap",   0, 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    add_vec("sra",        0, 5'b01101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    add_vec("srl",        0, 5'b00101, 32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    add_vec("sub_neg",    0, 5'b01000, 32'd5,         32'd7,         32'hFFFF_FFFE, 1);
    add_vec("sll_31",     0, 5'b00001, 32'h0000_0001, 32'd31,        32'h8000_0000, 1);
    add_vec("sll_shamt5", 0, 5'b00001, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1);
    add_vec("slt",        0, 5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    add_vec("sltu",       0, 5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    add_vec("xor",        0, 5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    add_vec("or",         0, 5'b00110, 32'h0F0F_0000, 32'h00F0_F00F, 32'h0FFF_F00F, 1);
    add_vec("and",        0, 5'b00111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    add_vec("pass",       0, 5'b01001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    add_vec("undef_1010", 0, 5'b01010, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1);
    add_vec("pass_again", 0, 5'b01001, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D, 1);
    add_vec("undef_1011", 0, 5'b01011, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1);
    add_vec("undef_1100", 0, 5'b01100, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1);
    add_vec("undef_1110", 0, 5'b01110, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1);
    add_vec("undef_1111", 0, 5'b01111, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1);
    // MUL vectors: latency 2k for k iterations
    add_vec("mul_7x6",    0, OP_MUL, 32'd7,         32'd6,         32'd42,        6);
    add_vec("mul_5x0",    0, OP_MUL, 32'd5,         32'd0,         32'd0,         2);
    add_vec("mul_1x1",    0, OP_MUL, 32'd1,         32'd1,         32'd1,         2);
    add_vec("mul_ffxff",  0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 64);
    add_vec("mul_3xmsb",  0, OP_MUL, 32'd3,         32'h8000_0000, 32'h8000_0000, 64);
    add_vec("mul_17it",   0, OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 34);
    add_vec("ne_mul_7x6", 1, OP_MUL, 32'd7,         32'd6,         32'd42,        64);
    add_vec("ne_mul_5x0", 1, OP_MUL, 32'd5,         32'd0,         32'd0,         64);

    // Reset state, sampled while reset is held
    #1;
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {30'd0, busy},      32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd3);
    check("rst_result0",   res0, 32'd0);
    check("rst_result1",   res1, 32'd0);

    // Release between edges so the next rising edge is the first with rst_n=1
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      consume(vecs[i].sel);
      check({vecs[i].name, "_idle"}, {31'd0, busy[vecs[i].sel]}, 32'd0);
    end

    // Backpressure: hold rsp_ready low 10 cycles with a pending request
    issue(0, 5'b00000, 32'd2, 32'd3, res, lat);
    check("bp_result", res, 32'd5);
    check("bp_latency", lat, 1);
    @(negedge clk);
    req_op = OP_MUL; req_a = 32'd9; req_b = 32'd9;
    req_valid[0] = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid[0] || res0 !== 32'd5 || req_ready[0] || !busy[0]) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    req_valid[0] = 1'b0;
    consume(0);
    check("bp_back_idle", {31'd0, req_ready[0]}, 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy[0] || rsp_valid[0]) seen = 1'b1;
    end
    check("bp_pending_dropped", {31'd0, seen}, 32'd0);
    check("bp_result_kept", res0, 32'd5);

    // Asynchronous reset in the middle of a long multiply
    @(negedge clk);
    req_op = OP_MUL; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy_before", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      {31'd0, busy[0]},      32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("mid_rst_result",    res0,                  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rsp_valid[0] || busy[0]) seen = 1'b1;
    end
    check("mid_rst_no_rsp", {31'd0, seen}, 32'd0);

    // First request after release is taken on the first rising edge
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    issue(0, 5'b00000, 32'd10, 32'd20, res, lat);
    check("first_after_rst_result", res, 32'd30);
    check("first_after_rst_latency", lat, 1);
    consume(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter MUL_EARLY_EXIT, default 1, meaning 1 = end multiply when the remaining multiplier is zero and 0 = always run 32 iterations.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port req_op, input, 5 bits: bit4=1 means MUL (low 32 bits, unsigned); bit4=0 means bits[3:0] is an ALU function code.
REQ-007 SHALL have port req_a, input, 32 bits: operand 1 / multiplicand.
REQ-008 SHALL have port req_b, input, 32 bits: operand 2 / multiplier.
REQ-009 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port rsp_result, output, 32 bits: result.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, MUL_ADD, MUL_SHIFT, RESP.
REQ-014 SHALL drive req_ready high only in IDLE; accept a request on an edge where req_valid and req_ready are both high, registering req_op, req_a and req_b.
REQ-015 SHALL, on accepting a non-MUL op at edge N, enter EXEC; at edge N+1 register the ALU output into rsp_result and enter RESP, so rsp_valid is high after edge N+1.
REQ-016 SHALL support ALU codes 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1001 pass op_1, 1101 sra; shift amount is op_2[4:0].
REQ-017 SHALL return 0x00000000 for undefined codes 1010, 1011, 1100, 1110 and 1111, and never hold a stale result for them.
REQ-018 SHALL, on accepting MUL, load acc=0, mcand=req_a, mplier=req_b, count=0 and enter MUL_ADD.
REQ-019 SHALL, in MUL_ADD, compute acc <= acc+mcand through the shared ALU (code 0000) if mplier[0]=1, otherwise hold acc; then go to MUL_SHIFT.
REQ-020 SHALL, in MUL_SHIFT, compute mcand <= mcand<<1 through the ALU (code 0001, op_2=1), set mplier <= mplier>>1 with a local shifter, and increment count.
REQ-021 SHALL leave MUL_SHIFT for RESP when count reaches 32 or (MUL_EARLY_EXIT=1 and the shifted mplier is 0), otherwise return to MUL_ADD.
REQ-022 SHALL therefore raise rsp_valid after edge N+2k for k iterations, with 1≤k≤32.
REQ-023 SHALL wrap all arithmetic modulo 2^32 with no overflow indication.
REQ-024 SHALL hold rsp_valid and rsp_result stable in RESP until rsp_ready=1, then return to IDLE on that edge; a new request is accepted at the earliest on the following edge.
REQ-025 SHALL ignore req_valid whenever req_ready=0; requests presented then are neither accepted nor lost-with-side-effects.
REQ-026 SHALL use exactly one ALU instance for every function code, all sequenced through it.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_result=0, busy=0, and acc, mcand, mplier and count to 0.
REQ-028 SHALL, when reset is asserted mid-operation (EXEC, MUL_*, RESP), abort the operation and produce no response for it after release.
REQ-029 SHALL make the first request after reset release acceptable on the first rising edge with rst_n=1.

Structure
REQ-030 SHALL take the state encoding, ALU function-code constants and the MUL op encoding (req_op[4]) from the shared package alu_seq_pkg.
REQ-031 SHALL instantiate the team's combinational ALU (ALU_top_module) as its only sub-module, with operand and function muxes driven by the FSM.

Verification
REQ-032 SHALL cover: ADD 0xFFFFFFFF+0x00000001 -> rsp_result 0x00000000, rsp_valid after N+1.
REQ-033 SHALL cover: SRA 0x80000000 by 4 (code 1101) -> 0xF8000000; SRL same operands -> 0x08000000.
REQ-034 SHALL cover: MUL 7×6 with MUL_EARLY_EXIT=1 -> 42, rsp_valid after N+6; MUL 5×0 -> 0 after N+2.
REQ-035 SHALL cover: MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001 after N+64; with MUL_EARLY_EXIT=0, 7×6 -> 42 after N+64.
REQ-036 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and rsp_result stable, req_ready=0 throughout, with a pending req_valid not accepted.
REQ-037 SHALL cover: rst_n pulsed low during a MUL iteration -> outputs at reset values asynchronously, no rsp_valid afterwards; undefined code 1010 -> 0x00000000.
